// File: rtl/mmu_seq_if.sv
// Valid/ready sample stream used on both sides of mmu_seq.
// The upstream (slave) side carries no frame marker, so last is master-only.
interface mmu_seq_if #(parameter int BITWIDTH = 24);
  logic                valid;
  logic                ready;
  logic                last;
  logic [BITWIDTH-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mmu_seq.sv
// Frame sequencer for mmu_buf: fills 2**DEPTH locations linearly, then drains them.
// Optional bit-reversed drain order is built only when MMU_SEQ_BITREV_EN is defined.
//
// state   | meaning
// FILL    | accepting upstream samples into the buffer, wr_cnt = next address
// WAIT_RD | frame written, waiting for mmu_buf to become readable
// DRAIN   | presenting buffer contents downstream, rd_cnt = next read index
module mmu_seq #(
  parameter int BITWIDTH = 24,
  parameter int DEPTH    = 3,
  parameter int FCW      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mmu_seq_if.slave            s,
  mmu_seq_if.master           m,
  input  logic                mode_bitrev,
  output logic                buf_wr_en,
  output logic [DEPTH-1:0]    buf_in_addr,
  output logic [BITWIDTH-1:0] buf_in_data,
  input  logic                buf_in_ready,
  output logic [DEPTH-1:0]    buf_out_addr,
  input  logic [BITWIDTH-1:0] buf_out_data,
  input  logic                buf_out_ready,
  output logic                busy,
  output logic [FCW-1:0]      frame_cnt
);

  typedef enum logic [1:0] {FILL, WAIT_RD, DRAIN} state_t;

  localparam logic [DEPTH-1:0] LAST_IDX = '1;

  state_t           state;
  logic [DEPTH-1:0] wr_cnt;
  logic [DEPTH-1:0] rd_cnt;
  logic             started;
  logic             accept;
  logic             m_fire;

  assign accept = s.valid & s.ready;
  assign m_fire = m.valid & m.ready;

  // The first sample of a frame must wait for mmu_buf to be back in IDLE.
  assign s.ready = started & (state == FILL) & ((wr_cnt != '0) | buf_in_ready);
  assign m.valid = (state == DRAIN);
  assign m.last  = (state == DRAIN) & (rd_cnt == LAST_IDX);
  assign m.data  = buf_out_data;
  assign busy    = ~((state == FILL) & (wr_cnt == '0));

`ifdef MMU_SEQ_BITREV_EN
  logic mode_q;

  function automatic logic [DEPTH-1:0] bit_rev(input logic [DEPTH-1:0] a);
    logic [DEPTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i] = a[DEPTH-1-i];
    return r;
  endfunction

  assign buf_out_addr = mode_q ? bit_rev(rd_cnt) : rd_cnt;
`else
  logic unused_mode;
  assign unused_mode  = mode_bitrev;
  assign buf_out_addr = rd_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      started     <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_in_addr <= '0;
      buf_in_data <= '0;
      frame_cnt   <= '0;
`ifdef MMU_SEQ_BITREV_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      started   <= 1'b1;
      buf_wr_en <= accept;
      // Address/data hold on a stall: mmu_buf rewrites them every loading cycle.
      if (accept) begin
        buf_in_addr <= wr_cnt;
        buf_in_data <= s.data;
        wr_cnt      <= wr_cnt + 1'b1;
      end
`ifdef MMU_SEQ_BITREV_EN
      if (accept && (wr_cnt == '0)) mode_q <= mode_bitrev;
`endif
      case (state)
        FILL: begin
          if (accept && (wr_cnt == LAST_IDX)) state <= WAIT_RD;
        end
        WAIT_RD: begin
          if (buf_out_ready) state <= DRAIN;
        end
        DRAIN: begin
          if (m_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_IDX) begin
              state     <= FILL;
              frame_cnt <= frame_cnt + 1'b1;
              wr_cnt    <= '0;
              rd_cnt    <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/mmu_seq.md
Name: mmu_seq

Overview:
- Frame sequencer for the WTU mmu_buf.
- Accepts a valid/ready sample stream and fills the buffer's 2**DEPTH locations in linear order.
- Waits for the buffer to become readable, then drains it to a downstream valid/ready stream in linear or bit-reversed address order.
- Sits between the upstream sample source and the transform datapath; owns every mmu_buf control input.

Parameters:
- BITWIDTH, 24, sample width; must match mmu_buf.
- DEPTH, 3, address width; WIDTH = 2**DEPTH locations per frame.
- FCW, 16, width of frame_cnt.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset; mmu_buf rst is driven from ~rst_n at top level
- s_valid  in  1  upstream sample valid
- s_data  in  BITWIDTH  upstream sample
- s_ready  out  1  sequencer accepts a sample this cycle
- m_valid  out  1  downstream sample valid
- m_data  out  BITWIDTH  downstream sample (= buf_out_data)
- m_last  out  1  marks the final sample of a frame
- m_ready  in  1  downstream accepts
- mode_bitrev  in  1  1 = bit-reversed drain order; sampled at first accept of each frame
- buf_wr_en  out  1  to mmu_buf wr_en
- buf_in_addr  out  DEPTH  to mmu_buf in_addr
- buf_in_data  out  BITWIDTH  to mmu_buf in_data
- buf_in_ready  in  1  from mmu_buf in_ready
- buf_out_addr  out  DEPTH  to mmu_buf out_addr
- buf_out_data  in  BITWIDTH  from mmu_buf out_data
- buf_out_ready  in  1  from mmu_buf out_ready
- busy  out  1  high in any state other than FILL with wr_cnt==0
- frame_cnt  out  FCW  count of completed frames; wraps

Behaviour:
- States:
  - FILL: FILL -> WAIT_RD after the accept with wr_cnt==WIDTH-1.
  - WAIT_RD: WAIT_RD -> DRAIN when buf_out_ready==1.
  - DRAIN: DRAIN -> FILL on the m_valid&m_ready&m_last handshake; frame_cnt++, wr_cnt and rd_cnt cleared.
- Reset values (asynchronous on rst_n low): state=FILL, wr_cnt=0, rd_cnt=0, buf_wr_en=0, buf_in_addr=0, buf_in_data=0, frame_cnt=0, mode latch=0. Outputs: s_ready=0 until the first clk edge after reset release, m_valid=0, m_last=0, busy=0.
- s_ready = (state==FILL) & (wr_cnt!=0 | buf_in_ready).
  - The first sample of a frame waits for the buffer to be in IDLE.
- Accept (s_valid&s_ready) registers buf_in_addr<=wr_cnt, buf_in_data<=s_data, buf_wr_en<=1; wr_cnt++.
  - Latency: the sample is written into the buffer at the edge 1 cycle after accept.
- Without accept, buf_wr_en<=0 and buf_in_addr/buf_in_data HOLD their last value.
  - Required because mmu_buf writes in_addr/in_data on every cycle while loading. A stall must only rewrite the last sample, never mark an unwritten location.
- buf_out_addr = rd_cnt when the mode latch is 0, bit-reverse(rd_cnt) when it is 1. Purely combinational from rd_cnt.
- DRAIN outputs:
  - m_valid = (state==DRAIN), independent of buf_out_ready. mmu_buf returns to IDLE the cycle after the last address is presented, but its memory remains stable because the sequencer issues no wr_en until DRAIN exits.
  - m_data = buf_out_data, combinational.
  - m_last = (state==DRAIN) & (rd_cnt==WIDTH-1).
- On m_valid&m_ready, rd_cnt++. With m_ready low, rd_cnt and buf_out_addr hold; re-marking a location read is harmless.
- Simultaneous events:
  - The last DRAIN handshake and s_valid in the same cycle: no accept that cycle; s_ready rises the next cycle.
  - The first accept of the next frame additionally requires buf_in_ready.
- frame_cnt wraps from 2**FCW-1 to 0.
- busy = ~(state==FILL & wr_cnt==0).
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded. mmu_buf resets in the same event.
- Throughput: 1 sample/cycle in each direction when unstalled.
- Minimum frame period is 2*WIDTH+2 cycles (FILL, WAIT_RD transition, DRAIN).

Optional Feature:
- MMU_SEQ_BITREV_EN.
- Defined: mode_bitrev is latched at the first accept of each frame and selects bit-reversed drain order as above.
- Undefined: mode_bitrev is ignored, no latch is built, and buf_out_addr = rd_cnt always.

Test Plan:
- Reset, then 8 back-to-back samples 1..8, m_ready=1, mode=0 -> m_data 1..8 in order, m_last only with 8, frame_cnt=1, s_ready high again after the last handshake.
- Same stream with mode_bitrev=1 (MMU_SEQ_BITREV_EN defined) -> m_data order 1,5,3,7,2,6,4,8.
- s_valid deasserted 3 cycles after samples 4 and 8 -> no corruption; output 1..8. Buffer enters READ only after sample 8's write.
- m_ready low for 5 cycles while m_last is presented -> m_valid and m_data=8 hold, s_ready stays 0 until the handshake.
- rst_n pulsed low after 5 accepts -> all outputs at reset values. A following full frame 11..18 drains exactly 11..18.
- 2**FCW+1 frames with FCW=4 -> frame_cnt wraps to 1.
